// File: rtl/exu_posit_pkg.sv
// rtl/exu_posit_pkg.sv - shared posit constants, FSM state type and decoded-field struct
package exu_posit_pkg;

    // Ceiling log2, used for shift-count and regime widths.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 4;
    localparam int POSIT_BS = log2(POSIT_N);
    localparam int SCALE_W  = POSIT_BS + POSIT_ES + 2;
    localparam int FRAC_W   = POSIT_N - POSIT_ES;
    localparam logic [POSIT_N-1:0] POSIT_NAR = {1'b1, {(POSIT_N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DECODE, SHIFT, ROUND} p2i_state_t;

    typedef struct packed {
        logic                       sgn;
        logic                       nar;
        logic                       zero;
        logic signed [SCALE_W-1:0]  scale;
        logic [FRAC_W-1:0]          frac;
    } posit_fields_t;

endpackage

// File: rtl/exu_posit_p2i_ctl_if.sv
// rtl/exu_posit_p2i_ctl_if.sv - start/busy/done request and result bundle of the posit-to-int converter
interface exu_posit_p2i_ctl_if;
    import exu_posit_pkg::*;

    logic                start;
    logic [POSIT_N-1:0]  in;
    logic                is_unsigned;
    logic                busy;
    logic                done;
    logic [POSIT_N-1:0]  out;
    logic                nv;
    logic                nx;

    modport master (output start, in, is_unsigned, input busy, done, out, nv, nx);
    modport slave  (input start, in, is_unsigned, output busy, done, out, nv, nx);
endinterface

// File: rtl/exu_posit_field_dec.sv
// rtl/exu_posit_field_dec.sv - combinational posit field decoder (leading-run regime, exponent, fraction)
module exu_posit_field_dec
    import exu_posit_pkg::*;
(
    input  logic [POSIT_N-1:0] posit,
    output posit_fields_t      fields
);

    localparam logic signed [SCALE_W-1:0] K_ONE = 1;

    logic [POSIT_N-2:0]         body;
    logic [POSIT_BS:0]          run;
    logic                       run_done;
    logic [POSIT_N-1:0]         rest;
    logic signed [SCALE_W-1:0]  kpos;
    logic signed [SCALE_W-1:0]  k;
    logic [POSIT_ES-1:0]        exp_bits;

    // Magnitude, regime run length, then strip regime+terminator to expose exponent and fraction.
    always_comb begin
        body     = posit[POSIT_N-1] ? (~posit[POSIT_N-2:0] + 1'b1) : posit[POSIT_N-2:0];
        run      = '0;
        run_done = 1'b0;
        for (int i = POSIT_N - 2; i >= 0; i--) begin
            if (!run_done && (body[i] == body[POSIT_N-2])) run = run + 1'b1;
            else run_done = 1'b1;
        end
        rest     = {body, 1'b0} << (run + 1'b1);
        kpos     = $signed({{(SCALE_W-POSIT_BS-1){1'b0}}, run});
        k        = body[POSIT_N-2] ? (kpos - K_ONE) : -kpos;
        exp_bits = rest[POSIT_N-1 -: POSIT_ES];

        fields.sgn   = posit[POSIT_N-1];
        fields.nar   = (posit == POSIT_NAR);
        fields.zero  = (posit == '0);
        fields.scale = (k <<< POSIT_ES) + $signed({{(SCALE_W-POSIT_ES){1'b0}}, exp_bits});
        fields.frac  = rest[FRAC_W-1:0];
    end

endmodule

// File: rtl/exu_posit_p2i_ctl.sv
// rtl/exu_posit_p2i_ctl.sv - multi-cycle posit to int32 converter; EXU_POSIT_P2I_SHIFT4_EN enables 4-bit shift steps
module exu_posit_p2i_ctl
    import exu_posit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    exu_posit_p2i_ctl_if.slave  p2i
);

    localparam int CNT_W = POSIT_BS + 1;
    localparam logic signed [SCALE_W-1:0] S_NM1  = SCALE_W'(POSIT_N - 1);
    localparam logic signed [SCALE_W-1:0] S_N    = SCALE_W'(POSIT_N);
    localparam logic signed [SCALE_W-1:0] S_SHMX = SCALE_W'(POSIT_N + 1);
    localparam logic [POSIT_N-1:0] INT_MAX  = {1'b0, {(POSIT_N-1){1'b1}}};
    localparam logic [POSIT_N-1:0] UINT_MAX = '1;

    p2i_state_t           state_q, state_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [POSIT_N-1:0]   out_q, out_d;
    logic                 nv_q, nv_d, nx_q, nx_d;
    logic [POSIT_N-1:0]   op_q, op_d;
    logic                 uns_q, uns_d, sgn_q, sgn_d;
    logic [POSIT_N-1:0]   m_q, m_d;
    logic                 g_q, g_d, st_q, st_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 spec_q, spec_d, res_nv_q, res_nv_d;
    logic [POSIT_N-1:0]   res_q, res_d;

    posit_fields_t              fld;
    logic signed [SCALE_W-1:0]  diff;
    logic [CNT_W-1:0]           sh;
    logic                       special;
    logic                       ulp;
    logic [POSIT_N:0]           r;

    exu_posit_field_dec u_dec (
        .posit  (op_q),
        .fields (fld)
    );

    assign p2i.busy = busy_q;
    assign p2i.done = done_q;
    assign p2i.out  = out_q;
    assign p2i.nv   = nv_q;
    assign p2i.nx   = nx_q;

    // Next-state, datapath and result computation for the whole conversion.
    always_comb begin
        state_d = state_q;   busy_d = busy_q;   done_d = 1'b0;
        out_d = out_q;       nv_d = nv_q;       nx_d = nx_q;
        op_d = op_q;         uns_d = uns_q;     sgn_d = sgn_q;
        m_d = m_q;           g_d = g_q;         st_d = st_q;     cnt_d = cnt_q;
        spec_d = spec_q;     res_d = res_q;     res_nv_d = res_nv_q;

        // Right-shift distance that brings the integer bit to position 0.
        diff = S_NM1 - $signed(fld.scale);
        if (diff[SCALE_W-1])  sh = '0;
        else if (diff > S_SHMX) sh = CNT_W'(POSIT_N + 1);
        else                  sh = diff[CNT_W-1:0];

        special = fld.nar | fld.zero
                | (!uns_q & ($signed(fld.scale) >= S_NM1))
                | ( uns_q & ($signed(fld.scale) >= S_N));

        ulp = g_q & (st_q | m_q[0]);
        r   = {1'b0, m_q} + {{POSIT_N{1'b0}}, ulp};

        case (state_q)
            IDLE: begin
                if (p2i.start) begin
                    op_d    = p2i.in;
                    uns_d   = p2i.is_unsigned;
                    busy_d  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                sgn_d    = fld.sgn;
                m_d      = {1'b1, fld.frac, {(POSIT_N-1-FRAC_W){1'b0}}};
                g_d      = 1'b0;
                st_d     = 1'b0;
                cnt_d    = sh;
                spec_d   = special;
                res_nv_d = 1'b1;
                if (fld.nar)       res_d = uns_q ? UINT_MAX : POSIT_NAR;
                else if (fld.zero) begin res_d = '0; res_nv_d = 1'b0; end
                else if (!uns_q)   res_d = fld.sgn ? POSIT_NAR : INT_MAX;
                else               res_d = UINT_MAX;
                state_d = (special || sh == '0) ? ROUND : SHIFT;
            end
            SHIFT: begin
`ifdef EXU_POSIT_P2I_SHIFT4_EN
                if (cnt_q >= CNT_W'(4)) begin
                    m_d   = m_q >> 4;
                    g_d   = m_q[3];
                    st_d  = st_q | g_q | (|m_q[2:0]);
                    cnt_d = cnt_q - CNT_W'(4);
                end else begin
                    m_d   = m_q >> 1;
                    g_d   = m_q[0];
                    st_d  = st_q | g_q;
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                m_d   = m_q >> 1;
                g_d   = m_q[0];
                st_d  = st_q | g_q;
                cnt_d = cnt_q - CNT_W'(1);
`endif
                if (cnt_d == '0) state_d = ROUND;
            end
            ROUND: begin
                nv_d = 1'b0;
                nx_d = g_q | st_q;
                if (spec_q) begin
                    out_d = res_q;  nv_d = res_nv_q;  nx_d = 1'b0;
                end else if (!uns_q) begin
                    if (!sgn_q && (r > {1'b0, INT_MAX})) begin
                        out_d = INT_MAX;  nv_d = 1'b1;  nx_d = 1'b0;
                    end else begin
                        out_d = sgn_q ? (~r[POSIT_N-1:0] + 1'b1) : r[POSIT_N-1:0];
                    end
                end else if (sgn_q) begin
                    out_d = '0;
                    if (r != '0) begin nv_d = 1'b1; nx_d = 1'b0; end
                end else begin
                    out_d = r[POSIT_N-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;  busy_q <= 1'b0;  done_q <= 1'b0;
            out_q <= '0;      nv_q <= 1'b0;    nx_q <= 1'b0;
            op_q <= '0;       uns_q <= 1'b0;   sgn_q <= 1'b0;
            m_q <= '0;        g_q <= 1'b0;     st_q <= 1'b0;    cnt_q <= '0;
            spec_q <= 1'b0;   res_q <= '0;     res_nv_q <= 1'b0;
        end else begin
            state_q <= state_d;  busy_q <= busy_d;  done_q <= done_d;
            out_q <= out_d;      nv_q <= nv_d;      nx_q <= nx_d;
            op_q <= op_d;        uns_q <= uns_d;    sgn_q <= sgn_d;
            m_q <= m_d;          g_q <= g_d;        st_q <= st_d;    cnt_q <= cnt_d;
            spec_q <= spec_d;    res_q <= res_d;    res_nv_q <= res_nv_d;
        end
    end

endmodule

// File: tb/tb_exu_posit_p2i_ctl.sv
// tb/tb_exu_posit_p2i_ctl.sv - directed and randomized bench for exu_posit_p2i_ctl
module tb_exu_posit_p2i_ctl;
    import exu_posit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    exu_posit_p2i_ctl_if p2i();

    exu_posit_p2i_ctl dut (
        .clk (clk),
        .rst (rst),
        .p2i (p2i.slave)
    );

    typedef struct {
        logic [31:0] p;
        bit          u;
        logic [31:0] o;
        bit          nv;
        bit          nx;
        int          sh;
    } vec_t;

    vec_t tbl [18] = '{
        '{32'h40000000, 1'b0, 32'h00000001, 1'b0, 1'b0, 31},
        '{32'h42800000, 1'b0, 32'h00000002, 1'b0, 1'b1, 30},
        '{32'h41000000, 1'b0, 32'h00000002, 1'b0, 1'b1, 31},
        '{32'h42C00000, 1'b0, 32'h00000003, 1'b0, 1'b1, 30},
        '{32'hBD800000, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 30},
        '{32'hC0000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 31},
        '{32'hC0000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 31},
        '{32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b0, -1},
        '{32'h80000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, -1},
        '{32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, -1},
        '{32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, -1},
        '{32'h80000001, 1'b0, 32'h80000000, 1'b1, 1'b0, -1},
        '{32'h3E000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 32},
        '{32'hC2000000, 1'b1, 32'h00000000, 1'b0, 1'b1, 32},
        '{32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, -1},
        '{32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1, 33},
        '{32'h6F000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 0},
        '{32'h6F000000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, -1}
    };

    function automatic int lat_of(input int sh);
        if (sh < 0) return 3;
`ifdef EXU_POSIT_P2I_SHIFT4_EN
        return 3 + sh / 4 + sh % 4;
`else
        return 3 + sh;
`endif
    endfunction

    // Reference: value = 1.frac * 2^scale as an exact integer ratio, rounded to nearest even.
    function automatic void model(input logic [31:0] p, input bit uns, output logic [31:0] o,
                                  output bit nv, output bit nx, output int sh);
        logic [31:0] mag;
        bit          neg, inexact, up;
        int          i, run, k, e, fbits, scale, d;
        longint      sig, ip, rem, half, r;
        o = 0; nv = 0; nx = 0; sh = -1;
        if (p == 32'h0) return;
        if (p == 32'h80000000) begin o = uns ? 32'hFFFFFFFF : 32'h80000000; nv = 1; return; end
        neg = p[31];
        mag = neg ? -p : p;
        i = 30; run = 0;
        while (i >= 0 && mag[i] == mag[30]) begin run++; i--; end
        k = mag[30] ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < 4; j++) begin e = e * 2 + ((i >= 0) ? int'(mag[i]) : 0); i--; end
        fbits = (i >= 0) ? i + 1 : 0;
        scale = k * 16 + e;
        if (!uns && scale >= 31) begin o = neg ? 32'h80000000 : 32'h7FFFFFFF; nv = 1; return; end
        if (uns && scale >= 32) begin o = 32'hFFFFFFFF; nv = 1; return; end
        sig = (longint'(1) << fbits) | (longint'(mag) & ((longint'(1) << fbits) - 1));
        if (scale >= fbits) begin
            ip = sig << (scale - fbits); inexact = 0; up = 0;
        end else begin
            d = fbits - scale;
            if (d > 62) begin
                ip = 0; inexact = 1; up = 0;
            end else begin
                ip = sig >> d;
                rem = sig & ((longint'(1) << d) - 1);
                half = longint'(1) << (d - 1);
                inexact = (rem != 0);
                up = (rem > half) || (rem == half && ip[0]);
            end
        end
        sh = 31 - scale;
        if (sh < 0) sh = 0;
        if (sh > 33) sh = 33;
        r = ip + longint'(up);
        if (!uns) begin
            if (!neg && r > 64'h7FFFFFFF) begin o = 32'h7FFFFFFF; nv = 1; end
            else begin o = neg ? 32'(-r) : 32'(r); nx = inexact; end
        end else if (neg) begin
            if (r != 0) nv = 1;
            else nx = inexact;
        end else begin
            o = 32'(r); nx = inexact;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] p, input bit uns);
        p2i.start = 1'b1;
        p2i.in = p;
        p2i.is_unsigned = uns;
    endtask

    // Waits for done (bounded), optionally pokes a start while busy, then checks the result.
    task automatic expect_conv(input string tag, input logic [31:0] eo, input bit env,
                               input bit enx, input int elat, input int poke);
        bit seen;
        int lat;
        seen = 0; lat = 0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(posedge clk); #1;
            p2i.start = 1'b0;
            if (c == poke) begin
                p2i.start = 1'b1; p2i.in = 32'h7FFFFFFF; p2i.is_unsigned = ~p2i.is_unsigned;
            end
            if (c == 1) chk({tag, ".busy1"}, 32'(p2i.busy), 32'd1);
            if (p2i.done) begin seen = 1; lat = c; end
        end
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, ".out"}, p2i.out, eo);
            chk({tag, ".nv"}, 32'(p2i.nv), 32'(env));
            chk({tag, ".nx"}, 32'(p2i.nx), 32'(enx));
            chk({tag, ".latency"}, 32'(lat), 32'(elat));
            chk({tag, ".busy_at_done"}, 32'(p2i.busy), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] v, eo;
        bit          u, env, enx, seen;
        int          esh;

        p2i.start = 1'b0; p2i.in = '0; p2i.is_unsigned = 1'b0;
        #12;
        chk("reset.busy", 32'(p2i.busy), 32'd0);
        chk("reset.done", 32'(p2i.done), 32'd0);
        chk("reset.out",  p2i.out, 32'd0);
        chk("reset.nv",   32'(p2i.nv), 32'd0);
        chk("reset.nx",   32'(p2i.nx), 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int n = 0; n < 18; n++) begin
            @(posedge clk); #1;
            launch(tbl[n].p, tbl[n].u);
            expect_conv($sformatf("dir%0d_%h", n, tbl[n].p), tbl[n].o, tbl[n].nv, tbl[n].nx,
                        lat_of(tbl[n].sh), 0);
            @(posedge clk); #1;
            chk($sformatf("dir%0d.done_pulse", n), 32'(p2i.done), 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            v = $urandom;
            case ($urandom_range(0, 3))
                1: v = {3'b010, v[28:0]};
                2: v = {4'b0110, v[27:0]};
                3: v = {4'b0011, v[27:0]};
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) v = -v;
            u = 1'($urandom_range(0, 1));
            model(v, u, eo, env, enx, esh);
            @(posedge clk); #1;
            launch(v, u);
            expect_conv($sformatf("rnd%0d_%h_u%0d", n, v, u), eo, env, enx, lat_of(esh), 0);
        end

        // Start while busy must be ignored and must not re-sample the operand.
        @(posedge clk); #1;
        launch(32'h40000000, 1'b0);
        expect_conv("busy_ignore", 32'h1, 1'b0, 1'b0, lat_of(31), 5);

        // Back-to-back: start presented on the done cycle is accepted.
        @(posedge clk); #1;
        launch(32'h42800000, 1'b0);
        expect_conv("b2b_a", 32'h2, 1'b0, 1'b1, lat_of(30), 0);
        launch(32'h41000000, 1'b1);
        expect_conv("b2b_b", 32'h2, 1'b0, 1'b1, lat_of(31), 0);

        // Reset in the middle of SHIFT: everything clears and no done follows.
        @(posedge clk); #1;
        launch(32'h40000000, 1'b0);
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; p2i.start = 1'b0; end
        rst = 1'b1; #1;
        chk("midrst.busy", 32'(p2i.busy), 32'd0);
        chk("midrst.done", 32'(p2i.done), 32'd0);
        chk("midrst.out",  p2i.out, 32'd0);
        chk("midrst.nv",   32'(p2i.nv), 32'd0);
        chk("midrst.nx",   32'(p2i.nx), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 45; c++) begin @(posedge clk); #1; if (p2i.done) seen = 1; end
        chk("midrst.no_done", 32'(seen), 32'd0);
        chk("midrst.out_hold", p2i.out, 32'd0);

        @(posedge clk); #1;
        launch(32'hC0000000, 1'b0);
        expect_conv("recover", 32'hFFFFFFFF, 1'b0, 1'b0, lat_of(31), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
